mar_load_arbiter: RTL

Sequences and shares the 16-bit MAR load path between three address sources: instruction fetch (program counter), operand address (from the temp/operand registers) and an external/DMA port. The block registers the winning address, drives it onto WBUS, and generates the active-low MAR load strobe `nLw` so the MAR captures it on the following falling edge of `CLK`. A one-cycle grant pulse then tells the winning source its address is in the MAR. Arbitration is fixed priority, with a starvation guard for the external port.

---
 rtl/mar_load_arbiter_if.sv | 24 ++
 rtl/mar_load_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/mar_load_arbiter_if.sv
// Handshake bundle between the three MAR address sources and the load arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface mar_load_arbiter_if;
  logic [2:0]  req;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] addr2;
  logic [2:0]  gnt;
  logic [15:0] WBUS_out;
  logic        wbus_en;
  logic        nLw;
  logic        busy;
  logic [1:0]  last_owner;

  modport master (
    output req, addr0, addr1, addr2,
    input  gnt, WBUS_out, wbus_en, nLw, busy, last_owner
  );

  modport slave (
    input  req, addr0, addr1, addr2,
    output gnt, WBUS_out, wbus_en, nLw, busy, last_owner
  );
endinterface

// File: rtl/mar_load_arbiter.sv
// Fixed-priority MAR load arbiter (fetch > operand > external) with a starvation
// guard for the external port. One MAR load every two cycles when saturated.
module mar_load_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic               CLK,
  input  logic               nCLR,
  mar_load_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  state_t        state;
  logic [2:0]    gnt_q;
  logic [15:0]   wbus_q;
  logic          en_q;
  logic          nlw_q;
  logic [1:0]    last_q;
  logic [1:0]    owner;
  logic [CW-1:0] cnt;

  logic [2:0]    elig;
  logic          any;
  logic [1:0]    win;
  logic [15:0]   win_addr;
  logic [CW-1:0] cnt_nxt;

  // The source being acknowledged cannot win the decision made in its own ACK cycle.
  always_comb begin
    elig = bus.req & ((state == ACK) ? ~gnt_q : 3'b111);
    any  = |elig;
    if (elig[2] && cnt == LIM) win = 2'd2;
    else if (elig[0])          win = 2'd0;
    else if (elig[1])          win = 2'd1;
    else                       win = 2'd2;
    case (win)
      2'd0:    win_addr = bus.addr0;
      2'd1:    win_addr = bus.addr1;
      default: win_addr = bus.addr2;
    endcase
    // Counter follows the raw external request, not the masked one.
    if (!bus.req[2] || win == 2'd2) cnt_nxt = '0;
    else if (cnt == LIM)            cnt_nxt = LIM;
    else                            cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state  <= IDLE;
      gnt_q  <= 3'b000;
      wbus_q <= 16'h0000;
      en_q   <= 1'b0;
      nlw_q  <= 1'b1;
      last_q <= 2'b11;
      owner  <= 2'd0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            wbus_q <= win_addr;
            en_q   <= 1'b1;
            nlw_q  <= 1'b0;
            owner  <= win;
            cnt    <= cnt_nxt;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          en_q   <= 1'b0;
          nlw_q  <= 1'b1;
          gnt_q  <= 3'b001 << owner;
          last_q <= owner;
          state  <= ACK;
        end
        ACK: begin
          gnt_q <= 3'b000;
          if (any) begin
            wbus_q <= win_addr;
            en_q   <= 1'b1;
            nlw_q  <= 1'b0;
            owner  <= win;
            cnt    <= cnt_nxt;
            state  <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.WBUS_out   = wbus_q;
  assign bus.wbus_en    = en_q;
  assign bus.nLw        = nlw_q;
  assign bus.busy       = (state != IDLE);
  assign bus.last_owner = last_q;
endmodule
